// File: rtl/motor_hbridge_driver_pkg.sv
// Shared encodings for the H-bridge driver: command modes, leg states and
// the bridge-level FSM states.
package motor_pkg;

  typedef enum logic [1:0] {
    MODE_COAST = 2'd0,
    MODE_FWD   = 2'd1,
    MODE_BRAKE = 2'd2,
    MODE_REV   = 2'd3
  } mode_t;

  // Used both as the per-leg request and as the leg FSM state.
  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HIGH = 2'd1,
    LEG_LOW  = 2'd2,
    LEG_DEAD = 2'd3
  } leg_t;

  typedef enum logic [2:0] {
    ST_COAST  = 3'd0,
    ST_FWD    = 3'd1,
    ST_REV    = 3'd2,
    ST_BRAKE  = 3'd3,
    ST_SWITCH = 3'd4
  } top_state_t;

  function automatic top_state_t mode_to_state(input mode_t m);
    case (m)
      MODE_FWD:   return ST_FWD;
      MODE_REV:   return ST_REV;
      MODE_BRAKE: return ST_BRAKE;
      default:    return ST_COAST;
    endcase
  endfunction

  function automatic logic is_reversal(input top_state_t s, input mode_t m);
    return ((s == ST_FWD) && (m == MODE_REV)) || ((s == ST_REV) && (m == MODE_FWD));
  endfunction

endpackage

// File: rtl/motor_hbridge_driver_if.sv
// Command inputs and gate/status outputs of the H-bridge driver.
interface motor_hbridge_driver_if;
  logic [1:0] Mode;
  logic [7:0] Duty;
  logic       HA;
  logic       LA;
  logic       HB;
  logic       LB;
  logic       Period_Start;
  logic       Reversing;

  modport master (
    output Mode, Duty,
    input  HA, LA, HB, LB, Period_Start, Reversing
  );

  modport slave (
    input  Mode, Duty,
    output HA, LA, HB, LB, Period_Start, Reversing
  );
endinterface

// File: rtl/motor_hbridge_driver_leg.sv
// One half-bridge leg: registered gate drive with dead-time on every
// high<->low change, immediate turn-off on an OFF request.
module hbridge_leg
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  leg_t req,
  output logic H,
  output logic L
);

  leg_t       r_state;
  logic [7:0] r_dcnt;
  logic       r_h;
  logic       r_l;
  logic       w_req_h;
  logic       w_req_l;

  assign w_req_h = (req == LEG_HIGH);
  assign w_req_l = (req == LEG_LOW);
  assign H       = r_h;
  assign L       = r_l;

  // At dead-time expiry the leg follows whatever is requested at that moment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= LEG_OFF;
      r_dcnt  <= '0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_h <= 1'b0;
      r_l <= 1'b0;
      if (!(w_req_h || w_req_l)) begin
        r_state <= LEG_OFF;
      end else begin
        case (r_state)
          LEG_OFF: begin
            r_state <= req;
            r_h     <= w_req_h;
            r_l     <= w_req_l;
          end
          LEG_HIGH, LEG_LOW: begin
            if (req == r_state) begin
              r_h <= w_req_h;
              r_l <= w_req_l;
            end else begin
              r_state <= LEG_DEAD;
              r_dcnt  <= 8'(DEADTIME - 1);
            end
          end
          LEG_DEAD: begin
            if (r_dcnt == '0) begin
              r_state <= req;
              r_h     <= w_req_h;
              r_l     <= w_req_l;
            end else begin
              r_dcnt <= r_dcnt - 8'd1;
            end
          end
          default: r_state <= LEG_OFF;
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_hbridge_driver.sv
// H-bridge driver top: prescaled 8-bit PWM, period-boundary command shadowing,
// bridge mode FSM with enforced coast on reversal, two dead-timed legs.
module motor_hbridge_driver
  import motor_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DEADTIME = 4
) (
  input logic                   CLK,
  input logic                   RST_N,
  motor_hbridge_driver_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic [7:0]    r_cnt;
  logic [7:0]    r_duty_s;
  top_state_t    r_state;
  logic          r_period_start;
  logic          r_reversing;
  logic          w_tick;
  logic          w_boundary;
  logic          w_pwm;
  mode_t         w_mode;
  leg_t          w_req_a;
  leg_t          w_req_b;
  logic          w_ha, w_la, w_hb, w_lb;

  assign w_mode     = mode_t'(bus.Mode);
  assign w_tick     = (r_pre == PW'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_cnt == 8'hFF);
  assign w_pwm      = (r_cnt < r_duty_s);

  // The bridge state register doubles as the mode shadow: it only moves at a boundary.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre          <= '0;
      r_cnt          <= '0;
      r_duty_s       <= '0;
      r_state        <= ST_COAST;
      r_period_start <= 1'b0;
      r_reversing    <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      if (w_boundary) begin
        r_duty_s <= bus.Duty;
        if (is_reversal(r_state, w_mode)) begin
          r_state     <= ST_SWITCH;
          r_reversing <= 1'b1;
        end else begin
          r_state     <= mode_to_state(w_mode);
          r_reversing <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_req_a = LEG_OFF;
    w_req_b = LEG_OFF;
    case (r_state)
      ST_FWD: begin
        w_req_a = w_pwm ? LEG_HIGH : LEG_LOW;
        w_req_b = LEG_LOW;
      end
      ST_REV: begin
        w_req_a = LEG_LOW;
        w_req_b = w_pwm ? LEG_HIGH : LEG_LOW;
      end
      ST_BRAKE: begin
        w_req_a = LEG_LOW;
        w_req_b = LEG_LOW;
      end
      default: ;
    endcase
  end

  hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req   (w_req_a),
    .H     (w_ha),
    .L     (w_la)
  );

  hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req   (w_req_b),
    .H     (w_hb),
    .L     (w_lb)
  );

  assign bus.HA           = w_ha;
  assign bus.LA           = w_la;
  assign bus.HB           = w_hb;
  assign bus.LB           = w_lb;
  assign bus.Period_Start = r_period_start;
  assign bus.Reversing    = r_reversing;

endmodule

// File: tb/tb_motor_hbridge_driver.sv
// Directed bench for motor_hbridge_driver: per-period gate occupancy counts
// against hand-computed values, plus a randomised PRESCALE=3 overlap sweep.
module tb_motor_hbridge_driver;

  logic CLK    = 1'b0;
  logic RST_N  = 1'b0;
  logic rst2_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int ha, la, hb, lb, off_a, ovl, rev, alloff, ha_rise;
  logic prev_ha;

  motor_hbridge_driver_if bus1();
  motor_hbridge_driver_if bus2();

  motor_hbridge_driver #(.PRESCALE(1), .DEADTIME(4)) dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  motor_hbridge_driver #(.PRESCALE(3), .DEADTIME(4)) dut2 (
    .CLK   (CLK),
    .RST_N (rst2_n),
    .bus   (bus2)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    ha = 0; la = 0; hb = 0; lb = 0; off_a = 0; ovl = 0; rev = 0; alloff = 0; ha_rise = 0;
    prev_ha = bus1.HA;
  endtask

  task automatic measure(input int len);
    for (int i = 0; i < len; i++) begin
      ha  += int'(bus1.HA);
      la  += int'(bus1.LA);
      hb  += int'(bus1.HB);
      lb  += int'(bus1.LB);
      rev += int'(bus1.Reversing);
      if (!bus1.HA && !bus1.LA) off_a++;
      if ((bus1.HA && bus1.LA) || (bus1.HB && bus1.LB)) ovl++;
      if (!bus1.HA && !bus1.LA && !bus1.HB && !bus1.LB) alloff++;
      if (bus1.HA && !prev_ha) ha_rise++;
      prev_ha = bus1.HA;
      step();
    end
  endtask

  task automatic period();
    clear_counts();
    measure(256);
  endtask

  task automatic wait_ps1(output int n);
    n = 0;
    while (!bus1.Period_Start && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ps2(output int n);
    n = 0;
    while (!bus2.Period_Start && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ovl2, bad_rev, ps_cnt, hold;
    logic prev_rev;

    bus1.Mode = 2'd0; bus1.Duty = 8'd0;
    bus2.Mode = 2'd0; bus2.Duty = 8'd0;
    #2;
    check_eq("rst_gates", int'({bus1.HA, bus1.LA, bus1.HB, bus1.LB}), 0);
    check_eq("rst_ps",    int'(bus1.Period_Start), 0);
    check_eq("rst_rev",   int'(bus1.Reversing), 0);
    repeat (3) step();

    // Forward, duty 64
    bus1.Mode = 2'd1; bus1.Duty = 8'd64;
    RST_N = 1'b1;
    wait_ps1(n);
    check_eq("first_ps", n, 256);
    period();                                   // P1, entry period
    period();                                   // P2 steady
    check_eq("d64_ha", ha, 60);
    check_eq("d64_la", la, 188);
    check_eq("d64_lb", lb, 256);
    check_eq("d64_hb", hb, 0);
    check_eq("d64_gap", off_a, 8);
    check_eq("d64_rise", ha_rise, 1);
    check_eq("d64_ovl", ovl, 0);
    check_eq("ps_align", int'(bus1.Period_Start), 1);

    // Duty 0: change mid-stream takes effect only next period
    bus1.Duty = 8'd0;
    period();                                   // P3
    check_eq("shadow_hold_ha", ha, 60);
    period();                                   // P4
    check_eq("d0_ha", ha, 0);
    check_eq("d0_la", la, 256);
    check_eq("d0_hb", hb, 0);
    check_eq("d0_lb", lb, 256);

    // Reversal FWD -> REV at duty 128, Mode changed mid-period
    bus1.Duty = 8'd128;
    period();                                   // P5 still duty 0
    check_eq("d0_hold_ha", ha, 0);
    clear_counts();
    measure(128);
    bus1.Mode = 2'd3;
    measure(128);                               // P6 FWD duty 128
    check_eq("pre_rev_ha", ha, 124);
    check_eq("pre_rev_hb", hb, 0);
    check_eq("pre_rev_rev", rev, 0);
    period();                                   // P7 SWITCH
    check_eq("sw_rev", rev, 256);
    check_eq("sw_alloff", alloff, 255);
    check_eq("sw_ovl", ovl, 0);
    period();                                   // P8 first REV
    check_eq("rev1_hb", hb, 128);
    check_eq("rev1_la", la, 255);
    check_eq("rev1_rev", rev, 0);
    period();                                   // P9 steady REV
    check_eq("rev_hb", hb, 124);
    check_eq("rev_lb", lb, 124);
    check_eq("rev_la", la, 256);
    check_eq("rev_ha", ha, 0);

    // Back to FWD at duty 200, then brake
    bus1.Mode = 2'd1; bus1.Duty = 8'd200;
    period();                                   // P10 REV
    period();                                   // P11 SWITCH
    check_eq("sw2_rev", rev, 256);
    period();                                   // P12
    period();                                   // P13
    check_eq("d200_ha", ha, 196);
    check_eq("d200_la", la, 52);
    bus1.Mode = 2'd2;
    period();                                   // P14 FWD
    period();                                   // P15 BRAKE
    check_eq("brk_la", la, 256);
    check_eq("brk_lb", lb, 256);
    check_eq("brk_h", ha + hb, 0);
    check_eq("brk_ovl", ovl, 0);

    // Duty below dead time: high side never turns on
    bus1.Mode = 2'd1; bus1.Duty = 8'd3;
    period();                                   // P16
    period();                                   // P17
    period();                                   // P18
    check_eq("d3_ha", ha, 0);
    check_eq("d3_la", la, 252);
    check_eq("d3_gap", off_a, 4);

    // Duty 255: one low count, swallowed by dead time
    bus1.Duty = 8'd255;
    period();                                   // P19
    period();                                   // P20
    period();                                   // P21
    check_eq("d255_ha", ha, 252);
    check_eq("d255_la", la, 0);

    // Asynchronous reset while HA is driven
    repeat (50) step();
    check_eq("pre_rst_ha", int'(bus1.HA), 1);
    #2 RST_N = 1'b0;
    #1;
    check_eq("async_rst_gates", int'({bus1.HA, bus1.LA, bus1.HB, bus1.LB}), 0);
    check_eq("async_rst_rev", int'(bus1.Reversing), 0);
    step();
    step();
    RST_N = 1'b1;
    wait_ps1(n);
    check_eq("ps_after_rst", n, 256);

    // PRESCALE=3 with random commands
    bus2.Mode = 2'd1; bus2.Duty = 8'd100;
    rst2_n = 1'b1;
    wait_ps2(n);
    check_eq("ps3_first", n, 768);
    ovl2 = 0; bad_rev = 0; ps_cnt = 0; hold = 1;
    prev_rev = bus2.Reversing;
    for (int i = 0; i < 20000; i++) begin
      if ((bus2.HA && bus2.LA) || (bus2.HB && bus2.LB)) ovl2++;
      if ((bus2.Reversing != prev_rev) && !bus2.Period_Start) bad_rev++;
      if (bus2.Period_Start) ps_cnt++;
      prev_rev = bus2.Reversing;
      hold--;
      if (hold == 0) begin
        bus2.Mode = 2'($urandom_range(0, 3));
        bus2.Duty = 8'($urandom_range(0, 255));
        hold = int'($urandom_range(1, 1000));
      end
      step();
    end
    check_eq("rnd_overlap", ovl2, 0);
    check_eq("rnd_rev_off_boundary", bad_rev, 0);
    check_eq("rnd_ps_count", ps_cnt, 27);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/motor_hbridge_driver.md
# motor_hbridge_driver

Consumes the Mode/Duty command pair produced by the motor speed/direction generator and drives the four gate signals of a full H-bridge. Duty is converted to an 8-bit PWM. Mode selects coast, forward, brake or reverse. Each bridge leg gets dead-time insertion so that its high and low switches are never on together. Commands are shadowed at PWM period boundaries, so output waveforms are glitch-free.

## Interface
- PRESCALE, default 1: number of CLK cycles per PWM count step (≥1).
- DEADTIME, default 4: CLK cycles both switches of a leg stay off on any H↔L change (≥1, <256).
- CLK, input, 1: system clock, rising edge.
- RST_N, input, 1: reset. Asynchronous, active-low.
- Mode, input, 2: 0 coast, 1 forward, 2 brake, 3 reverse.
- Duty, input, 8: PWM on-count per 256-step period.
- HA, input/output?: HA, output, 1: leg A high-side gate.
- LA, output, 1: leg A low-side gate.
- HB, output, 1: leg B high-side gate.
- LB, output, 1: leg B low-side gate.
- Period_Start, output, 1: one-CLK pulse when the PWM counter wraps to 0.
- Reversing, output, 1: high during the enforced coast period of a direction reversal.

## Operation
- Prescaler counts 0..PRESCALE-1. Tick = the prescaler at its terminal count. PRESCALE=1 gives a tick every cycle.
- 8-bit PWM counter cnt increments on each tick and wraps 255→0.
- Boundary = the tick on which cnt wraps.
  - At each boundary, Mode and Duty are latched into shadow registers.
  - Between boundaries, input changes have no effect.
- pwm = (cnt < duty_s).
  - duty_s=0 → pwm never high.
  - duty_s=255 → pwm high 255 of 256 counts.
- Top FSM states: COAST, FWD, REV, BRAKE, SWITCH. Transitions occur only at a boundary, driven by the shadowed mode:
  - FWD→REV or REV→FWD: go to SWITCH for one full period (all legs OFF, Reversing=1), then enter the new direction at the next boundary.
  - All other mode changes: go directly to the new state.
  - SWITCH honours the latest shadowed mode at its exit boundary.
- Leg requests per state (leg A, leg B):
  - COAST: OFF, OFF.
  - FWD: A = pwm ? H : L; B = L.
  - REV: A = L; B = pwm ? H : L.
  - BRAKE: L, L.
  - SWITCH: OFF, OFF.
- Duty 0 in FWD/REV is therefore a low-side brake (synchronous rectification).
- Each leg FSM has states OFF, HIGH, LOW, DEAD:
  - OFF→HIGH or OFF→LOW: immediate.
  - HIGH↔LOW: passes through DEAD for exactly DEADTIME cycles, then goes to the request current at expiry.
  - A request of OFF from any state: immediate OFF.
  - Gate outputs decode from leg state: HIGH→H=1, LOW→L=1, otherwise both 0.
- Invariant: HA&LA and HB&LB are never 1 in the same cycle.

## Timing
- Reset (async assert) clears HA, LA, HB, LB, Period_Start, Reversing, the counters, duty_s and the FSMs. Mode_s = coast.
- Outputs are registered. A leg request change appears on the gates 1 CLK later, plus DEADTIME when it crosses H↔L.
- A shadow value latched at a boundary first affects the gates 1 CLK after the boundary.
- Per period (PRESCALE=1, DUTY>DEADTIME, steady FWD):
  - HA high for Duty−DEADTIME cycles.
  - LA high for 256−Duty−DEADTIME cycles.
  - LB high continuously.
- If Duty ≤ DEADTIME, HA never asserts and LA still observes dead time.
- Period_Start asserts in the cycle after a boundary, coincident with cnt=0.
- RST_N asserted mid-pulse forces all gates to 0 immediately. After release, the first boundary is 256×PRESCALE ticks later.

## Structure
- Package motor_pkg:
  - MODE_COAST/FWD/BRAKE/REV encodings.
  - Leg request/state enum (OFF, HIGH, LOW, DEAD).
  - Top FSM state enum.
- Sub-module hbridge_leg (parameter DEADTIME; ports CLK, RST_N, req, H, L), instantiated twice.
- Top module holds the prescaler, PWM counter, shadow registers and the top FSM.

## Test plan
- RST_N low during FWD with HA=1 → HA, LA, HB, LB = 0 the same cycle. Reversing=0. Period_Start silent until 256 cycles after release.
- Mode=1, Duty=64, defaults → each period: HA high 60 cycles, LA high 188, LB constant 1, HB 0. Exactly 4-cycle gaps at both HA/LA edges.
- Mode=1, Duty=0 → after the first boundary, LA=LB=1 continuously, HA=HB=0.
- Mode 1→3 changed mid-period (Duty=128):
  - No change until the boundary.
  - Then 256 cycles of all gates 0 with Reversing=1.
  - Then HB PWM of 124 cycles, LA=1.
- Mode=2 from FWD, Duty=200 → at the boundary, LA/LB=1 and HA/HB=0 with no overlap.
- Random Mode/Duty every 1–1000 cycles, PRESCALE=3 → HA&LA and HB&LB are never both 1. Changes occur only after boundaries.
